// File: rtl/decode_issue_queue.sv
// decode_issue_queue
//   Circular instruction queue between decode and execute. Buffers decoded
//   bundles with PC and a vsetvl-class flag. Once a vsetvl-class entry
//   issues, the queue holds every later entry until execute pulses
//   vsetvl_done.
//
//   Optional feature macro: DECODE_QUEUE_BYPASS_EN. When defined, an empty,
//   idle queue presents the incoming bundle combinationally. If the bundle
//   is not stalled, it issues without being stored.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   flush_queue         drop all entries, clear barrier (beats enq/deq/done)
//   stall_queue         block dequeue
//   queue_wen, wdata,
//   wpc, wvsetvl        enqueue request from decode
//   vsetvl_done         execute retired the config write (releases barrier)
//   rvalid, rdata,
//   rpc, rvsetvl        head entry presented to execute
//   is_queue_full,
//   almost_full, count  occupancy, derived from registered count
//   overflow_err        sticky, enqueue attempted while full (cleared by RST)
module decode_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 64,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush_queue,
  input  logic                       stall_queue,
  input  logic                       queue_wen,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [31:0]                wpc,
  input  logic                       wvsetvl,
  input  logic                       vsetvl_done,
  output logic                       rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic [31:0]                rpc,
  output logic                       rvsetvl,
  output logic                       is_queue_full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic              vsetvl;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  entry_t          mem [DEPTH];
  entry_t          wr_ent, head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  state_e          state_q, state_d;
  logic            stored_vld, byp, byp_issue, deq, deq_mem, enq;

  assign wr_ent        = '{data: wdata, pc: wpc, vsetvl: wvsetvl};
  assign is_queue_full = (count == CW'(DEPTH));
  assign almost_full   = (count >= CW'(AF_THRESH));

  // Stored head is only offered while no vsetvl is outstanding.
  assign stored_vld = (count != '0) & (state_q == IDLE);

`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp  = (count == '0) & (state_q == IDLE) & queue_wen & ~flush_queue;
  assign head = byp ? wr_ent : mem[rd_ptr];
`else
  assign byp  = 1'b0;
  assign head = mem[rd_ptr];
`endif

  assign rvalid  = stored_vld | byp;
  assign rdata   = head.data;
  assign rpc     = head.pc;
  assign rvsetvl = head.vsetvl;

  assign deq       = rvalid & ~stall_queue & ~flush_queue;
  // A bypassed bundle that issues this cycle never touches storage.
  assign byp_issue = byp & deq;
  assign deq_mem   = deq & ~byp_issue;
  // Full comes from the registered count, so a same-cycle dequeue does not
  // make room for a write into a full queue.
  assign enq       = queue_wen & ~is_queue_full & ~flush_queue & ~byp_issue;

  // Barrier FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (deq & head.vsetvl)            state_d = WAIT;
      WAIT: if (flush_queue | vsetvl_done)    state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Pointers, count, storage, sticky overflow
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (queue_wen & is_queue_full & ~flush_queue) overflow_err <= 1'b1;
      if (flush_queue) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          mem[wr_ptr] <= wr_ent;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (deq_mem) rd_ptr <= rd_ptr + PW'(1);
        case ({enq, deq_mem})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_decode_issue_queue.sv
module tb_decode_issue_queue;
  localparam int DEPTH = 4;
  localparam int DATA_W = 64;
  localparam int AF_THRESH = DEPTH - 1;
`ifdef DECODE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0, RST, flush_queue, stall_queue, queue_wen, wvsetvl, vsetvl_done;
  logic [DATA_W-1:0] wdata;
  logic [31:0] wpc;
  logic rvalid, rvsetvl, is_queue_full, almost_full, overflow_err;
  logic [DATA_W-1:0] rdata;
  logic [31:0] rpc;
  logic [$clog2(DEPTH):0] count;

  decode_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AF_THRESH(AF_THRESH)) dut (
    .CLK(CLK), .RST(RST), .flush_queue(flush_queue), .stall_queue(stall_queue),
    .queue_wen(queue_wen), .wdata(wdata), .wpc(wpc), .wvsetvl(wvsetvl),
    .vsetvl_done(vsetvl_done), .rvalid(rvalid), .rdata(rdata), .rpc(rpc),
    .rvsetvl(rvsetvl), .is_queue_full(is_queue_full), .almost_full(almost_full),
    .count(count), .overflow_err(overflow_err));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] data;
    logic [31:0] pc;
    logic        vs;
  } ment_t;

  ment_t mq[$];
  bit    m_bar, m_ovf;
  int    vectors = 0, errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_byp();
    return BYP && mq.size() == 0 && !m_bar && queue_wen && !flush_queue;
  endfunction

  function automatic bit m_valid();
    return (mq.size() != 0 && !m_bar) || m_byp();
  endfunction

  // Compare every DUT output against the model for the current inputs.
  task automatic check_model();
    bit ev;
    ev = m_valid();
    chk("rvalid", 64'(rvalid), 64'(ev));
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(is_queue_full), 64'(mq.size() == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(mq.size() >= AF_THRESH));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    if (ev) begin
      if (mq.size() != 0) begin
        chk("rdata", rdata, mq[0].data);
        chk("rpc", 64'(rpc), 64'(mq[0].pc));
        chk("rvsetvl", 64'(rvsetvl), 64'(mq[0].vs));
      end else begin
        chk("byp_rdata", rdata, wdata);
        chk("byp_rpc", 64'(rpc), 64'(wpc));
        chk("byp_rvsetvl", 64'(rvsetvl), 64'(wvsetvl));
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic model_edge();
    bit full, v, d, hv;
    ment_t e;
    if (RST) begin
      mq.delete(); m_bar = 0; m_ovf = 0;
    end else if (flush_queue) begin
      mq.delete(); m_bar = 0;
    end else begin
      full = (mq.size() == DEPTH);
      v = m_valid();
      d = v && !stall_queue;
      if (queue_wen && full) m_ovf = 1;
      if (m_byp() && d) begin
        if (wvsetvl) m_bar = 1;
      end else begin
        hv = 0;
        if (d) begin hv = mq[0].vs; void'(mq.pop_front()); end
        if (queue_wen && !full) begin
          e.data = wdata; e.pc = wpc; e.vs = wvsetvl;
          mq.push_back(e);
        end
        if (d && hv) m_bar = 1;
        else if (m_bar && vsetvl_done) m_bar = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    check_model();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drv(input bit wen, input logic [63:0] d, input logic [31:0] pc,
                     input bit vs, input bit st, input bit fl, input bit dn);
    queue_wen = wen; wdata = d; wpc = pc; wvsetvl = vs;
    stall_queue = st; flush_queue = fl; vsetvl_done = dn;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    RST = 1; idle();
    @(posedge CLK); #1;
    tick();
    RST = 0;
    // reset state, everything zero
    #1;
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rpc", 64'(rpc), 0);
    chk("rst_rvsetvl", 64'(rvsetvl), 0);
    chk("rst_full", 64'(is_queue_full), 0);
    chk("rst_af", 64'(almost_full), 0);
    chk("rst_ovf", 64'(overflow_err), 0);

    // fill to full while stalled, then overflow
    for (int i = 0; i < 4; i++) begin
      drv(1, 64'hA + i, 32'h100 + 4 * i, 0, 1, 0, 0); tick();
    end
    idle(); stall_queue = 1;
    chk("fill_count", 64'(count), 4);
    chk("fill_full", 64'(is_queue_full), 1);
    chk("fill_af", 64'(almost_full), 1);
    chk("pre_ovf", 64'(overflow_err), 0);
    drv(1, 64'hE, 32'h110, 0, 1, 0, 0); tick();
    idle();
    chk("ovf_set", 64'(overflow_err), 1);
    chk("ovf_count", 64'(count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", rdata, 64'hA + i);
      chk("drain_pc", 64'(rpc), 64'h100 + 4 * i);
      tick();
    end
    chk("drain_empty", 64'(rvalid), 0);

    // wrap: hold count at 2 with simultaneous enq+deq
    for (int i = 0; i < 2; i++) begin drv(1, 64'h20 + i, 32'h200 + i, 0, 1, 0, 0); tick(); end
    for (int i = 0; i < 10; i++) begin drv(1, 64'h22 + i, 32'h300 + i, 0, 0, 0, 0); tick(); end
    idle(); stall_queue = 1;
    chk("wrap_count", 64'(count), 2);
    chk("wrap_head", rdata, 64'h2A);
    idle(); tick(); tick();

    // barrier: X(vsetvl) then Y
    drv(1, 64'h58, 32'h400, 1, 1, 0, 0); tick();
    drv(1, 64'h59, 32'h404, 0, 1, 0, 0); tick();
    idle(); tick();  // X issues
    for (int i = 0; i < 3; i++) begin chk("bar_hold", 64'(rvalid), 0); tick(); end
    stall_queue = 1; vsetvl_done = 1; tick();
    vsetvl_done = 0;
    chk("bar_release", 64'(rvalid), 1);
    chk("bar_y", rdata, 64'h59);
    idle(); tick();

    // flush in WAIT with 3 entries and a concurrent write
    drv(1, 64'h60, 32'h500, 1, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin drv(1, 64'h61 + i, 32'h504 + 4 * i, 0, 1, 0, 0); tick(); end
    idle(); tick();  // vsetvl entry issues, WAIT with 3 left
    chk("pre_flush_count", 64'(count), 3);
    drv(1, 64'h77, 32'h600, 0, 0, 1, 0); tick();
    idle();
    chk("flush_count", 64'(count), 0);
    chk("flush_rvalid", 64'(rvalid), 0);
    chk("flush_ovf", 64'(overflow_err), 1);
    drv(1, 64'h78, 32'h604, 0, 1, 0, 0); tick();
    idle(); stall_queue = 1;
    chk("flush_idle", 64'(rvalid), 1);

    // stall with 2 entries for 5 cycles
    drv(1, 64'h79, 32'h608, 0, 1, 0, 0); tick();
    idle(); stall_queue = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_head", rdata, 64'h78);
      chk("stall_count", 64'(count), 2);
    end
    idle(); tick();
    chk("release1", rdata, 64'h79);
    tick();
    chk("release2", 64'(count), 0);

    // same-cycle presentation only with the bypass
    drv(1, 64'h55, 32'h700, 0, 0, 0, 0); #2;
    chk("byp_rvalid", 64'(rvalid), 64'(BYP));
    tick();
    idle(); stall_queue = 1;
    chk("byp_count", 64'(count), BYP ? 0 : 1);
    chk("byp_next", 64'(rvalid), BYP ? 0 : 1);
    idle(); tick(); tick();

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      RST = ($urandom_range(0, 199) == 0);
      drv($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom,
          $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
      tick();
    end
    RST = 0; idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
